pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//  Memory-side responder for the cache's physical-memory port. Accepts one 128-bit
//  line read or write (lc3b_line) from the cache controller. Serves it as a burst
//  of 8 sequential 16-bit word accesses on a req/ack word-memory port, then pulses
//  pmem_resp. Sits between the L1 cache and the board SRAM/word memory.
// PARAMETERS
//  LINE_WORDS  8   words per line; fixed by lc3b_line (128b) / lc3b_word (16b)
//  WORD_W      16  word width in bits
//  ADDR_W      16  byte address width
// PORTS
//  clk          in   1    single clock, rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  pmem_read    in   1    cache line-read request, held until pmem_resp
//  pmem_write   in   1    cache line-write request, held until pmem_resp
//  pmem_address in   16   byte address {tag[8:0],index[2:0],offset[2:0],byte}; bits [3:0] ignored
//  pmem_wdata   in   128  line to write; word k = bits [16k+15:16k]
//  pmem_rdata   out  128  line read back; valid when pmem_resp=1 for a read
//  pmem_resp    out  1    one-cycle completion pulse
//  mem_req      out  1    word access request
//  mem_we       out  1    1 = word write, 0 = word read; valid while mem_req=1
//  mem_addr     out  16   word byte address {line_addr[15:4], k[2:0], 1'b0}
//  mem_wdata    out  16   write word k
//  mem_rdata    in   16   read data; sampled in the cycle mem_ack=1
//  mem_ack      in   1    word access complete; ignored when mem_req=0
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, k=0, all outputs 0, pmem_rdata=0.
//   Asserting reset mid-burst abandons the transfer and drops mem_req at once.
//   No pmem_resp is produced for the abandoned line.
//  FSM: IDLE -> XFER -> RESP -> IDLE.
//   IDLE: when pmem_read|pmem_write, latch line_addr=pmem_address[15:4].
//    Latch wdata and op (write wins if both asserted; both together is illegal), set k=0.
//    Go to XFER next cycle.
//   XFER: mem_req=1, mem_we=op, addr/wdata from latched values and k. Outputs
//    stay stable until mem_ack. On mem_ack: for a read, capture mem_rdata into
//    line word k. If k==7, go to RESP; else k<=k+1 and keep mem_req=1 with the next address.
//   RESP: pmem_resp=1 for exactly one cycle; mem_req=0; next state IDLE.
//  Latency with zero-wait memory (ack same cycle as req): request seen in IDLE at
//   cycle 0, words in cycles 1..8, pmem_resp in cycle 9. Each wait cycle adds 1.
//  pmem_rdata is registered and updated only by a read. It holds the last read line
//   through later writes and idle time.
//  pmem_address, pmem_wdata and request changes after latching are ignored until IDLE.
//   The request is re-sampled only in IDLE. Back-to-back transactions (e.g. a
//   writeback followed by a fill) therefore have 1 idle cycle between them.
//  k is 3 bits and never wraps past 7 within a burst. The word address never carries out of the line.
//  Words are issued strictly in order 0..7, one outstanding access at a time.
// TESTING
//  1 Reset: hold reset_n=0, drive pmem_read=1 -> mem_req=0, pmem_resp=0, pmem_rdata=0.
//  2 Read 0x1230, mem acks same cycle, word k=0x1000+k -> addrs 0x1230..0x123E step 2.
//    pmem_resp at cycle 9; pmem_rdata=0x1007_1006_..._1000.
//  3 Write 0x00F8 (line 0x00F0), wdata word k=0xA0A0+k -> 8 writes mem_we=1 at
//    0x00F0..0x00FE with matching data; pmem_resp once; pmem_rdata unchanged.
//  4 Read with 3-cycle ack delay per word -> req/addr stable while waiting;
//    pmem_resp at cycle 9+8*3=33; no duplicate or skipped word.
//  5 reset_n pulsed low while k=4 -> mem_req drops immediately; no pmem_resp. A new
//    read afterwards starts again at word 0.
//  6 pmem_read and pmem_write both high -> write performed; also check writeback
//    then fill back-to-back gives 2 distinct pmem_resp pulses.

Source files
------------

// File: rtl/pmem_line_responder.sv
// ---------------------------------------------------------------------------
// pmem_line_responder
//
// Memory-side responder for the cache's physical-memory port. A 128-bit line
// read or write from the cache controller is served as a burst of eight
// sequential 16-bit word accesses on a req/ack word-memory port. Completion is
// signalled by a single-cycle pmem_resp pulse.
//
// Ports
//   clk           single clock, rising edge
//   reset_n       asynchronous, active-low reset
//   pmem_read     line-read request, held by the cache until pmem_resp
//   pmem_write    line-write request, held by the cache until pmem_resp
//   pmem_address  byte address of the line; the low offset/byte bits are ignored
//   pmem_wdata    line to write; word k = bits [16k+15:16k]
//   pmem_rdata    last line read back; valid while pmem_resp=1 after a read
//   pmem_resp     one-cycle completion pulse
//   mem_req       word access request
//   mem_we        1 = word write, 0 = word read (meaningful while mem_req=1)
//   mem_addr      word byte address {line_addr, k, 1'b0}
//   mem_wdata     word k of the latched write line
//   mem_rdata     read data, sampled in the cycle mem_ack=1
//   mem_ack       word access complete; ignored while mem_req=0
// ---------------------------------------------------------------------------
module pmem_line_responder #(
    parameter int LINE_WORDS = 8,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         pmem_read,
    input  logic                         pmem_write,
    input  logic [ADDR_W-1:0]            pmem_address,
    input  logic [LINE_WORDS*WORD_W-1:0] pmem_wdata,
    output logic [LINE_WORDS*WORD_W-1:0] pmem_rdata,
    output logic                         pmem_resp,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic [WORD_W-1:0]            mem_rdata,
    input  logic                         mem_ack
);

    // Word index width, and the width of the line address left once the
    // word index and the byte-within-word bit are removed.
    localparam int K_W  = $clog2(LINE_WORDS);
    localparam int LA_W = ADDR_W - K_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP
    } state_t;

    state_t            state_reg;
    logic [K_W-1:0]    k_reg;
    logic [LA_W-1:0]   line_addr_reg;
    logic              op_write_reg;
    logic              req_reg;
    logic              resp_reg;
    logic [WORD_W-1:0] wdata_words_reg [LINE_WORDS];
    logic [WORD_W-1:0] rdata_words_reg [LINE_WORDS];

    // Offset and byte bits of the request address carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[K_W:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            line_addr_reg <= '0;
            op_write_reg  <= 1'b0;
            req_reg       <= 1'b0;
            resp_reg      <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                wdata_words_reg[i] <= '0;
                rdata_words_reg[i] <= '0;
            end
        end else begin
            resp_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Request is only sampled here; everything the burst
                    // needs is latched so later input changes are ignored.
                    if (pmem_read || pmem_write) begin
                        line_addr_reg <= pmem_address[ADDR_W-1:K_W+1];
                        op_write_reg  <= pmem_write;   // write wins if both
                        k_reg         <= '0;
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            wdata_words_reg[i] <= pmem_wdata[i*WORD_W +: WORD_W];
                        end
                        req_reg   <= 1'b1;
                        state_reg <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // req/addr/data hold until ack; then either step to the
                    // next word (req stays high) or finish the line.
                    if (mem_ack) begin
                        if (!op_write_reg) begin
                            rdata_words_reg[k_reg] <= mem_rdata;
                        end
                        if (k_reg == K_W'(LINE_WORDS - 1)) begin
                            req_reg   <= 1'b0;
                            resp_reg  <= 1'b1;
                            state_reg <= ST_RESP;
                        end else begin
                            k_reg <= k_reg + K_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign pmem_resp = resp_reg;
    assign mem_req   = req_reg;
    assign mem_we    = req_reg & op_write_reg;
    assign mem_addr  = {line_addr_reg, k_reg, 1'b0};
    assign mem_wdata = wdata_words_reg[k_reg];

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_rdata
            assign pmem_rdata[gi*WORD_W +: WORD_W] = rdata_words_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder. A small transaction model predicts,
// for every cycle of a line transfer, which word must be on the word port and
// when the completion pulse must appear; a word-memory responder with a
// configurable ack delay serves the burst.
module tb_pmem_line_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_ack;

    pmem_line_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Current transaction as seen by the model.
    bit           t_active = 1'b0;
    int           t_start  = 0;
    bit           t_wr     = 1'b0;
    logic [15:0]  t_addr   = '0;
    logic [127:0] t_wdata  = '0;
    int           t_delay  = 0;
    logic [15:0]  t_rbase  = '0;
    logic [127:0] prev_line = '0;

    int           resp_count    = 0;
    int           last_resp_cyc = 0;
    int           ack_count     = 0;
    logic [15:0]  wlog_addr[$];
    logic [15:0]  wlog_data[$];

    function automatic logic [127:0] line_of(input logic [15:0] base);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = base + 16'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, 2 time units after the rising edge.
    always @(posedge clk) begin
        int c;
        int wlen;
        int rc;
        int w;
        logic [2:0] w3;
        bit exp_req;
        #2;
        if (reset_n) begin
            if (pmem_resp) begin
                resp_count++;
                last_resp_cyc = cyc;
            end
            if (t_active) begin
                c       = cyc - t_start;
                wlen    = t_delay + 1;          // cycles each word occupies
                rc      = 8 * wlen + 1;         // completion cycle
                exp_req = (c >= 1) && (c <= 8 * wlen);
                chk("mem_req", 128'(mem_req), 128'(exp_req));
                chk("pmem_resp", 128'(pmem_resp), 128'(c == rc));
                if (exp_req) begin
                    w  = (c - 1) / wlen;
                    w3 = w[2:0];
                    chk("mem_addr", 128'(mem_addr), 128'({t_addr[15:4], w3, 1'b0}));
                    chk("mem_we", 128'(mem_we), 128'(t_wr));
                    if (t_wr) chk("mem_wdata", 128'(mem_wdata), 128'(t_wdata[16*w +: 16]));
                end
                if (t_wr || c == 0) chk("pmem_rdata_hold", pmem_rdata, prev_line);
                else if (c >= rc)   chk("pmem_rdata_line", pmem_rdata, line_of(t_rbase));
            end else begin
                chk("idle_mem_req", 128'(mem_req), 128'(0));
                chk("idle_pmem_resp", 128'(pmem_resp), 128'(0));
                chk("idle_pmem_rdata", pmem_rdata, prev_line);
            end
        end
    end

    // Word memory: acks after t_delay wait cycles; read data encodes the word index.
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt == t_delay) begin
            mem_ack   = 1'b1;
            wait_cnt  = 0;
            ack_count++;
            mem_rdata = t_rbase + ((mem_addr >> 1) & 16'h7);
            if (mem_we) begin
                wlog_addr.push_back(mem_addr);
                wlog_data.push_back(mem_wdata);
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            wait_cnt++;
        end
    end

    // Called just after a falling edge. 'chained' means the DUT is in its
    // completion cycle, so the request is first sampled one cycle later.
    task automatic start_txn(input bit wr, input bit rd, input logic [15:0] addr,
                             input logic [127:0] wd, input int delay,
                             input logic [15:0] rbase, input bit chained);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        t_wr    = wr;
        t_addr  = addr;
        t_wdata = wd;
        t_delay = delay;
        t_rbase = rbase;
        t_start = chained ? cyc + 1 : cyc;
        t_active = 1'b1;
    endtask

    // Runs to the falling edge of the completion cycle; scrambles the line
    // inputs mid-burst to show they are not re-sampled.
    task automatic finish_txn(input bit drop);
        int rc;
        int n;
        rc = 8 * (t_delay + 1) + 1;
        n  = 0;
        while ((cyc - t_start) < rc && n < 200) begin
            @(negedge clk);
            n++;
            if (cyc - t_start == 2) begin
                pmem_address = ~pmem_address;
                pmem_wdata   = ~pmem_wdata;
            end
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL txn_timeout: got no completion after %0d cycles, required %0d", n, rc);
        end
        t_active = 1'b0;
        if (!t_wr) prev_line = line_of(t_rbase);
        if (drop) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] wd;
        int rc0;
        int first_resp;
        int n;

        // 1: reset held with a request pending
        reset_n      = 1'b0;
        pmem_read    = 1'b1;
        pmem_write   = 1'b0;
        pmem_address = 16'h1230;
        pmem_wdata   = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);
        chk("reset_mem_req", 128'(mem_req), 128'(0));
        chk("reset_pmem_resp", 128'(pmem_resp), 128'(0));
        chk("reset_pmem_rdata", pmem_rdata, 128'(0));
        chk("reset_mem_we", 128'(mem_we), 128'(0));
        pmem_read = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);

        // 2: zero-wait read of line 0x1230
        ack_count = 0;
        start_txn(1'b0, 1'b1, 16'h1230, '0, 0, 16'h1000, 1'b0);
        finish_txn(1'b1);
        chk("t2_latency", 128'(last_resp_cyc - t_start), 128'(9));
        chk("t2_line", pmem_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
        chk("t2_acks", 128'(ack_count), 128'(8));
        @(negedge clk);

        // 3: write of line 0x00F0 via address 0x00F8
        for (int i = 0; i < 8; i++) wd[16*i +: 16] = 16'hA0A0 + 16'(i);
        wlog_addr.delete();
        wlog_data.delete();
        rc0 = resp_count;
        start_txn(1'b1, 1'b0, 16'h00F8, wd, 0, 16'hBEEF, 1'b0);
        finish_txn(1'b1);
        chk("t3_writes", 128'(wlog_addr.size()), 128'(8));
        for (int i = 0; i < 8 && i < wlog_addr.size(); i++) begin
            chk("t3_waddr", 128'(wlog_addr[i]), 128'(16'h00F0 + 16'(2*i)));
            chk("t3_wdata", 128'(wlog_data[i]), 128'(16'hA0A0 + 16'(i)));
        end
        chk("t3_resp_once", 128'(resp_count - rc0), 128'(1));
        chk("t3_rdata_kept", pmem_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
        repeat (2) @(negedge clk);

        // 4: read with 3 wait cycles per word
        ack_count = 0;
        start_txn(1'b0, 1'b1, 16'h2460, '0, 3, 16'h5500, 1'b0);
        finish_txn(1'b1);
        chk("t4_latency", 128'(last_resp_cyc - t_start), 128'(33));
        chk("t4_acks", 128'(ack_count), 128'(8));
        chk("t4_line", pmem_rdata, 128'h5507_5506_5505_5504_5503_5502_5501_5500);
        @(negedge clk);

        // 5: reset while word 4 is on the port
        start_txn(1'b0, 1'b1, 16'h3450, '0, 0, 16'h6600, 1'b0);
        n = 0;
        while ((cyc - t_start) < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_at_word4", 128'(mem_addr), 128'(16'h3458));
        t_active  = 1'b0;
        rc0       = resp_count;
        reset_n   = 1'b0;
        pmem_read = 1'b0;
        #1;
        chk("t5_req_drop", 128'(mem_req), 128'(0));
        chk("t5_rdata_cleared", pmem_rdata, 128'(0));
        prev_line = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_resp", 128'(resp_count - rc0), 128'(0));
        start_txn(1'b0, 1'b1, 16'h3450, '0, 1, 16'h6600, 1'b0);
        finish_txn(1'b1);
        chk("t5_line", pmem_rdata, 128'h6607_6606_6605_6604_6603_6602_6601_6600);
        @(negedge clk);

        // 6: read+write together performs a write, then a chained fill
        for (int i = 0; i < 8; i++) wd[16*i +: 16] = 16'hC3C0 + 16'(i);
        wlog_addr.delete();
        wlog_data.delete();
        rc0 = resp_count;
        start_txn(1'b1, 1'b1, 16'h4440, wd, 0, 16'h7700, 1'b0);
        finish_txn(1'b0);
        first_resp = last_resp_cyc;
        start_txn(1'b0, 1'b1, 16'h4450, '0, 0, 16'h7700, 1'b1);
        finish_txn(1'b1);
        chk("t6_writes", 128'(wlog_addr.size()), 128'(8));
        if (wlog_addr.size() > 7) begin
            chk("t6_waddr0", 128'(wlog_addr[0]), 128'(16'h4440));
            chk("t6_wdata7", 128'(wlog_data[7]), 128'(16'hC3C7));
        end
        chk("t6_two_resps", 128'(resp_count - rc0), 128'(2));
        chk("t6_resp_gap", 128'(last_resp_cyc - first_resp), 128'(10));
        chk("t6_line", pmem_rdata, 128'h7707_7706_7705_7704_7703_7702_7701_7700);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
